// File: rtl/regfile_scb.sv
// Architectural register file with a per-register busy scoreboard.
// Two combinational read ports with optional same-cycle writeback forwarding,
// one writeback port, and an issue-side reservation port that marks a
// register as having an outstanding producer until its writeback arrives.
module regfile_scb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wen_i,
  input  logic [AW-1:0]   rd_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  output logic [XLEN-1:0] src1_o,
  output logic [XLEN-1:0] src2_o,
  input  logic            rsv_en_i,
  input  logic [AW-1:0]   rsv_rd_i,
  input  logic            flush_i,
  output logic            busy1_o,
  output logic            busy2_o,
  output logic            rsv_busy_o,
  output logic            waw_err_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic            waw_q;

  logic            wr_ok;
  logic            rsv_ok;
  logic            fwd_ok;
  logic            fwd1;
  logic            fwd2;
  logic            waw_set;

  // Index 0 is hardwired when ZERO_REG is set: never written, never reserved.
  function automatic logic is_zero_idx(input logic [AW-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // Array read with the hardwired-zero register applied.
  function automatic logic [XLEN-1:0] arr_read(input logic [AW-1:0] idx);
    if (is_zero_idx(idx))
      return '0;
    else
      return regs_q[idx];
  endfunction

  assign wr_ok  = wen_i && !is_zero_idx(rd_i);
  assign rsv_ok = rsv_en_i && !flush_i && !is_zero_idx(rsv_rd_i);

  // Forwarding is only legal outside reset and never for the hardwired zero.
  assign fwd_ok = (BYPASS != 0) && !rst_i && wr_ok;
  assign fwd1   = fwd_ok && (rd_i == rs1_i);
  assign fwd2   = fwd_ok && (rd_i == rs2_i);

  // Read ports: array contents, overridden by the in-flight writeback.
  always_comb begin
    src1_o  = fwd1 ? wdata_i : arr_read(rs1_i);
    src2_o  = fwd2 ? wdata_i : arr_read(rs2_i);
    busy1_o = busy_q[rs1_i] && !fwd1;
    busy2_o = busy_q[rs2_i] && !fwd2;
  end

  assign rsv_busy_o = busy_q[rsv_rd_i];
  assign waw_err_o  = waw_q;

  // A reservation on a register whose producer is still outstanding is a WAW
  // hazard, unless that producer retires in this very cycle.
  assign waw_set = rsv_en_i && !flush_i && busy_q[rsv_rd_i]
                   && !(wen_i && (rd_i == rsv_rd_i));

  // Next busy vector: writeback clears, reservation sets (set wins), flush
  // clears everything and swallows any same-cycle reservation.
  always_comb begin
    busy_nxt = busy_q;
    if (flush_i) begin
      busy_nxt = '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wen_i && (rd_i == AW'(i)))
          busy_nxt[i] = 1'b0;
        if (rsv_ok && (rsv_rd_i == AW'(i)))
          busy_nxt[i] = 1'b1;
      end
    end
  end

  // Register array: writeback port; reset zeroes the whole architectural state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[rd_i] <= wdata_i;
    end
  end

  // Scoreboard state: busy bits and the sticky WAW error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (waw_set)
        waw_q <= 1'b1;
    end
  end

endmodule
